mod_cmd_sequencer: RTL

MOD_CMD_SEQUENCER -- requirements
Module: mod_cmd_sequencer

---
 rtl/mod_cmd_pkg.sv | 19 +
 rtl/mod_cmd_fifo.sv | 40 ++++
 rtl/mod_cmd_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mod_cmd_pkg.sv
// Shared definitions for the command sequencer: FSM state encoding and
// default sizing constants.
package mod_cmd_pkg;

  localparam int DEF_REG_WIDTH      = 32;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    WR_REQ,
    RD_WAIT,
    WR_WAIT,
    CAPTURE,
    RESP
  } seq_state_e;

endpackage

// File: rtl/mod_cmd_fifo.sv
// Synchronous command queue; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count.
module mod_cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mod_cmd_sequencer.sv
// Queues client register commands and replays them one at a time onto the
// Master_Interface request lines, returning one response per command.
module mod_cmd_sequencer
  import mod_cmd_pkg::*;
#(
  parameter int REG_WIDTH      = DEF_REG_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WR,
  input  logic [REG_WIDTH-1:0] CMD_ADDR,
  input  logic [REG_WIDTH-1:0] CMD_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic                 RSP_WR,
  output logic                 RSP_ERR,
  output logic [REG_WIDTH-1:0] RSP_DATA,
  output logic                 MOD_2_M_RRQST,
  output logic [REG_WIDTH-1:0] MOD_2_M_RADDR,
  output logic                 MOD_2_M_WARQST,
  output logic [REG_WIDTH-1:0] MOD_2_M_WADDR,
  output logic                 MOD_2_M_WRQST,
  output logic [REG_WIDTH-1:0] MOD_2_M_WDATA,
  input  logic                 ARREADY,
  input  logic                 AWREADY,
  input  logic                 WREADY,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 BVALID,
  input  logic                 BREADY,
  input  logic [REG_WIDTH-1:0] M_2_MOD_RDATA,
  input  logic                 M_2_MOD_WRESULT,
  output logic                 BUSY
);
  localparam int               CMD_W   = 2 * REG_WIDTH + 1;
  localparam int               WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  seq_state_e state, state_n;
  logic [WDW-1:0] wdog, wdog_n;
  logic cur_wr, cur_wr_n;
  logic fifo_full, fifo_empty, pop;
  logic [CMD_W-1:0] head;
  logic head_wr;
  logic [REG_WIDTH-1:0] head_addr, head_wdata;

  logic rrqst_n, warqst_n, wrqst_n;
  logic [REG_WIDTH-1:0] raddr_n, waddr_n, wdata_n;
  logic rsp_valid_n, rsp_wr_n, rsp_err_n;
  logic [REG_WIDTH-1:0] rsp_data_n;

  mod_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (CMD_VALID),
    .push_data ({CMD_WR, CMD_ADDR, CMD_WDATA}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_wr, head_addr, head_wdata} = head;
  assign CMD_READY = !fifo_full;
  assign BUSY      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_n     = state;
    wdog_n      = wdog;
    cur_wr_n    = cur_wr;
    pop         = 1'b0;
    rrqst_n     = MOD_2_M_RRQST;
    raddr_n     = MOD_2_M_RADDR;
    warqst_n    = MOD_2_M_WARQST;
    waddr_n     = MOD_2_M_WADDR;
    wrqst_n     = MOD_2_M_WRQST;
    wdata_n     = MOD_2_M_WDATA;
    rsp_valid_n = RSP_VALID;
    rsp_wr_n    = RSP_WR;
    rsp_err_n   = RSP_ERR;
    rsp_data_n  = RSP_DATA;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_wr_n = head_wr;
          wdog_n   = '0;
          if (head_wr) begin
            state_n  = WR_REQ;
            warqst_n = 1'b1;
            wrqst_n  = 1'b1;
            waddr_n  = head_addr;
            wdata_n  = head_wdata;
          end else begin
            state_n = RD_REQ;
            rrqst_n = 1'b1;
            raddr_n = head_addr;
          end
        end
      end
      RD_REQ, WR_REQ, RD_WAIT, WR_WAIT: begin
        wdog_n = wdog + 1'b1;
        // Watchdog expiry overrides any handshake landing on the same edge.
        if (wdog == WD_LAST) begin
          rrqst_n     = 1'b0;
          raddr_n     = '0;
          warqst_n    = 1'b0;
          waddr_n     = '0;
          wrqst_n     = 1'b0;
          wdata_n     = '0;
          rsp_valid_n = 1'b1;
          rsp_wr_n    = cur_wr;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
          state_n     = RESP;
        end else begin
          unique case (state)
            RD_REQ: if (ARREADY) begin
              rrqst_n = 1'b0;
              raddr_n = '0;
              state_n = RD_WAIT;
            end
            WR_REQ: if (AWREADY && WREADY) begin
              warqst_n = 1'b0;
              waddr_n  = '0;
              wrqst_n  = 1'b0;
              wdata_n  = '0;
              state_n  = WR_WAIT;
            end
            RD_WAIT: if (RVALID && RREADY) state_n = CAPTURE;
            WR_WAIT: if (BVALID && BREADY) state_n = CAPTURE;
            default: ;
          endcase
        end
      end
      CAPTURE: begin
        rsp_valid_n = 1'b1;
        rsp_wr_n    = cur_wr;
        rsp_err_n   = 1'b0;
        rsp_data_n  = cur_wr ? {{(REG_WIDTH-1){1'b0}}, M_2_MOD_WRESULT} : M_2_MOD_RDATA;
        state_n     = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state          <= IDLE;
      wdog           <= '0;
      cur_wr         <= 1'b0;
      MOD_2_M_RRQST  <= 1'b0;
      MOD_2_M_RADDR  <= '0;
      MOD_2_M_WARQST <= 1'b0;
      MOD_2_M_WADDR  <= '0;
      MOD_2_M_WRQST  <= 1'b0;
      MOD_2_M_WDATA  <= '0;
      RSP_VALID      <= 1'b0;
      RSP_WR         <= 1'b0;
      RSP_ERR        <= 1'b0;
      RSP_DATA       <= '0;
    end else begin
      state          <= state_n;
      wdog           <= wdog_n;
      cur_wr         <= cur_wr_n;
      MOD_2_M_RRQST  <= rrqst_n;
      MOD_2_M_RADDR  <= raddr_n;
      MOD_2_M_WARQST <= warqst_n;
      MOD_2_M_WADDR  <= waddr_n;
      MOD_2_M_WRQST  <= wrqst_n;
      MOD_2_M_WDATA  <= wdata_n;
      RSP_VALID      <= rsp_valid_n;
      RSP_WR         <= rsp_wr_n;
      RSP_ERR        <= rsp_err_n;
      RSP_DATA       <= rsp_data_n;
    end
  end

endmodule
